// File: rtl/param_down_counter_pkg.sv
// Shared types for the parametrised down-counter: mode encoding and FSM states.
package param_down_counter_pkg;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'b00,
    MODE_SAT     = 2'b01,
    MODE_ONESHOT = 2'b10,
    MODE_RELOAD  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

endpackage

// File: rtl/param_down_counter_decrementer_core.sv
// Combinational subtract-with-borrow used for every counter update.
module decrementer_core #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] step,
  output logic [WIDTH-1:0] diff,
  output logic             uf,
  output logic             hit
);

  logic [WIDTH:0] full;

  // One extra bit so the borrow falls out of the subtraction directly.
  assign full = {1'b0, a} - {1'b0, step};
  assign diff = full[WIDTH-1:0];
  assign uf   = full[WIDTH];
  assign hit  = (step >= a) && (step != '0);

endmodule

// File: rtl/param_down_counter.sv
// Loadable down-counter with programmable step and wrap/saturate/one-shot/reload
// behaviour at zero, plus registered borrow and terminal-count pulses.
module param_down_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic [WIDTH-1:0] step,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] out,
  output logic             borrow_out,
  output logic             tc,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  import param_down_counter_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             borrow_q, borrow_d;
  logic             tc_q, tc_d;

  logic [WIDTH-1:0] diff;
  logic             uf;
  logic             hit;

  decrementer_core #(
    .WIDTH(WIDTH)
  ) u_dec (
    .a   (out_q),
    .step(step),
    .diff(diff),
    .uf  (uf),
    .hit (hit)
  );

  always_comb begin
    state_d  = state_q;
    out_d    = out_q;
    reload_d = reload_q;
    borrow_d = 1'b0;
    tc_d     = 1'b0;

    if (load) begin
      out_d    = load_val;
      reload_d = load_val;
      state_d  = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start && !stop) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_IDLE;
          end else begin
            // step == 0 needs no special case: diff == out, uf == 0, hit == 0.
            borrow_d = uf;
            tc_d     = hit;
            case (mode_t'(mode))
              MODE_WRAP:    out_d = diff;
              MODE_SAT:     out_d = uf ? '0 : diff;
              MODE_ONESHOT: begin
                if (hit) begin
                  out_d   = '0;
                  state_d = S_DONE;
                end else begin
                  out_d = diff;
                end
              end
              MODE_RELOAD:  out_d = hit ? reload_q : diff;
              default:      out_d = diff;
            endcase
          end
        end
        S_DONE: begin
          state_d = S_DONE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      out_q    <= '0;
      reload_q <= '0;
      borrow_q <= 1'b0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      out_q    <= out_d;
      reload_q <= reload_d;
      borrow_q <= borrow_d;
      tc_q     <= tc_d;
    end
  end

  assign out        = out_q;
  assign borrow_out = borrow_q;
  assign tc         = tc_q;
  assign zero       = (out_q == '0);
  assign busy       = (state_q == S_RUN);
  assign done       = (state_q == S_DONE);

endmodule

// File: tb/tb_param_down_counter.sv
// Scoreboard bench for param_down_counter at WIDTH=4: one task per scenario.
module tb_param_down_counter;

  typedef struct packed {
    logic       load;
    logic [3:0] lv;
    logic       start;
    logic       stop;
    logic [3:0] step;
    logic [1:0] mode;
  } stim_t;

  typedef struct packed {
    logic [3:0] out;
    logic       borrow;
    logic       tc;
    logic       zero;
    logic       busy;
    logic       done;
  } obs_t;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] load_val;
  logic       start;
  logic       stop;
  logic [3:0] step;
  logic [1:0] mode;
  logic [3:0] out;
  logic       borrow_out;
  logic       tc;
  logic       zero;
  logic       busy;
  logic       done;

  obs_t  obs;
  obs_t  want;
  obs_t  sb[$];
  stim_t st[$];
  obs_t  ex[$];
  int    checks = 0;
  int    errors = 0;

  param_down_counter #(
    .WIDTH(4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .stop      (stop),
    .step      (step),
    .mode      (mode),
    .out       (out),
    .borrow_out(borrow_out),
    .tc        (tc),
    .zero      (zero),
    .busy      (busy),
    .done      (done)
  );

  assign obs = {out, borrow_out, tc, zero, busy, done};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic stim_t row(bit ld, int lv, bit sta, bit stp, int stv, int md);
    stim_t r;
    r.load  = ld;
    r.lv    = 4'(lv);
    r.start = sta;
    r.stop  = stp;
    r.step  = 4'(stv);
    r.mode  = 2'(md);
    return r;
  endfunction

  function automatic obs_t expv(int o, bit b, bit t, bit bsy, bit dn);
    obs_t e;
    e.out    = 4'(o);
    e.borrow = b;
    e.tc     = t;
    e.zero   = (o == 0);
    e.busy   = bsy;
    e.done   = dn;
    return e;
  endfunction

  function automatic string fmt(obs_t v);
    return $sformatf("out=%0d borrow=%0b tc=%0b zero=%0b busy=%0b done=%0b",
                     v.out, v.borrow, v.tc, v.zero, v.busy, v.done);
  endfunction

  task automatic apply(stim_t s);
    load     = s.load;
    load_val = s.lv;
    start    = s.start;
    stop     = s.stop;
    step     = s.step;
    mode     = s.mode;
  endtask

  task automatic test_reset();
    apply(row(0, 0, 0, 0, 1, 0));
    rst_n = 1'b0;
    #12;
    sb.push_back(expv(0, 0, 0, 0, 0));
    want = sb.pop_front(); checks++;
    if (obs !== want) begin
      errors++; $display("FAIL reset_state got %s want %s", fmt(obs), fmt(want));
    end
    @(negedge clk); rst_n = 1'b1;

    st.delete(); ex.delete();
    st.push_back(row(1, 5, 0, 0, 1, 0)); ex.push_back(expv(5, 0, 0, 0, 0));
    st.push_back(row(0, 0, 1, 0, 1, 0)); ex.push_back(expv(5, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 1, 0)); ex.push_back(expv(4, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 1, 0)); ex.push_back(expv(3, 0, 0, 1, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      want = sb.pop_front(); checks++;
      if (obs !== want) begin
        errors++; $display("FAIL reset_run[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
    end

    // Asynchronous clear: no clock edge between assertion and the check.
    #2; rst_n = 1'b0; #1;
    sb.push_back(expv(0, 0, 0, 0, 0));
    want = sb.pop_front(); checks++;
    if (obs !== want) begin
      errors++; $display("FAIL reset_async got %s want %s", fmt(obs), fmt(want));
    end

    start = 1'b1;
    sb.push_back(expv(0, 0, 0, 0, 0));
    @(posedge clk); #1;
    want = sb.pop_front(); checks++;
    if (obs !== want) begin
      errors++; $display("FAIL reset_start_held got %s want %s", fmt(obs), fmt(want));
    end

    @(negedge clk); rst_n = 1'b1; start = 1'b1;
    sb.push_back(expv(0, 0, 0, 1, 0));
    @(posedge clk); #1;
    want = sb.pop_front(); checks++;
    if (obs !== want) begin
      errors++; $display("FAIL reset_start_after got %s want %s", fmt(obs), fmt(want));
    end
  endtask

  task automatic test_wrap();
    st.delete(); ex.delete();
    st.push_back(row(1, 1, 0, 0, 1, 0)); ex.push_back(expv(1, 0, 0, 0, 0));
    st.push_back(row(0, 0, 1, 0, 1, 0)); ex.push_back(expv(1, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 1, 0)); ex.push_back(expv(0, 0, 1, 1, 0));
    st.push_back(row(0, 0, 0, 0, 1, 0)); ex.push_back(expv(15, 1, 1, 1, 0));
    st.push_back(row(0, 0, 0, 0, 1, 0)); ex.push_back(expv(14, 0, 0, 1, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      want = sb.pop_front(); checks++;
      if (obs !== want) begin
        errors++; $display("FAIL wrap[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
    end
  endtask

  task automatic test_saturate();
    st.delete(); ex.delete();
    st.push_back(row(1, 5, 0, 0, 2, 1)); ex.push_back(expv(5, 0, 0, 0, 0));
    st.push_back(row(0, 0, 1, 0, 2, 1)); ex.push_back(expv(5, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 2, 1)); ex.push_back(expv(3, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 2, 1)); ex.push_back(expv(1, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 2, 1)); ex.push_back(expv(0, 1, 1, 1, 0));
    st.push_back(row(0, 0, 0, 0, 2, 1)); ex.push_back(expv(0, 1, 1, 1, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      want = sb.pop_front(); checks++;
      if (obs !== want) begin
        errors++; $display("FAIL saturate[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
    end
  endtask

  task automatic test_oneshot();
    st.delete(); ex.delete();
    st.push_back(row(1, 10, 0, 0, 3, 2)); ex.push_back(expv(10, 0, 0, 0, 0));
    st.push_back(row(0, 0, 1, 0, 3, 2));  ex.push_back(expv(10, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 3, 2));  ex.push_back(expv(7, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 3, 2));  ex.push_back(expv(4, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 3, 2));  ex.push_back(expv(1, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 3, 2));  ex.push_back(expv(0, 1, 1, 0, 1));
    st.push_back(row(0, 0, 1, 0, 3, 2));  ex.push_back(expv(0, 0, 0, 0, 1));
    st.push_back(row(0, 0, 0, 1, 3, 2));  ex.push_back(expv(0, 0, 0, 0, 1));
    st.push_back(row(1, 6, 0, 0, 3, 2));  ex.push_back(expv(6, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      want = sb.pop_front(); checks++;
      if (obs !== want) begin
        errors++; $display("FAIL oneshot[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
    end
  endtask

  task automatic test_reload();
    st.delete(); ex.delete();
    st.push_back(row(1, 4, 0, 0, 2, 3)); ex.push_back(expv(4, 0, 0, 0, 0));
    st.push_back(row(0, 0, 1, 0, 2, 3)); ex.push_back(expv(4, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 2, 3)); ex.push_back(expv(2, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 2, 3)); ex.push_back(expv(4, 0, 1, 1, 0));
    st.push_back(row(0, 0, 0, 0, 2, 3)); ex.push_back(expv(2, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 2, 3)); ex.push_back(expv(4, 0, 1, 1, 0));
    st.push_back(row(0, 0, 0, 0, 0, 3)); ex.push_back(expv(4, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 0, 3)); ex.push_back(expv(4, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 2, 3)); ex.push_back(expv(2, 0, 0, 1, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      want = sb.pop_front(); checks++;
      if (obs !== want) begin
        errors++; $display("FAIL reload[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
    end
  endtask

  task automatic test_mode_switch();
    st.delete(); ex.delete();
    st.push_back(row(1, 2, 0, 0, 1, 1)); ex.push_back(expv(2, 0, 0, 0, 0));
    st.push_back(row(0, 0, 1, 0, 1, 1)); ex.push_back(expv(2, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 1, 1)); ex.push_back(expv(1, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 1, 1)); ex.push_back(expv(0, 0, 1, 1, 0));
    st.push_back(row(0, 0, 0, 0, 1, 0)); ex.push_back(expv(15, 1, 1, 1, 0));
    st.push_back(row(0, 0, 0, 0, 5, 2)); ex.push_back(expv(10, 0, 0, 1, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      want = sb.pop_front(); checks++;
      if (obs !== want) begin
        errors++; $display("FAIL mode_switch[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
    end
  endtask

  task automatic test_priority();
    st.delete(); ex.delete();
    st.push_back(row(1, 12, 0, 0, 3, 0)); ex.push_back(expv(12, 0, 0, 0, 0));
    st.push_back(row(0, 0, 1, 0, 3, 0));  ex.push_back(expv(12, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 0, 3, 0));  ex.push_back(expv(9, 0, 0, 1, 0));
    st.push_back(row(1, 3, 1, 1, 3, 0));  ex.push_back(expv(3, 0, 0, 0, 0));
    st.push_back(row(0, 0, 1, 1, 3, 0));  ex.push_back(expv(3, 0, 0, 0, 0));
    st.push_back(row(0, 0, 1, 0, 1, 0));  ex.push_back(expv(3, 0, 0, 1, 0));
    st.push_back(row(0, 0, 0, 1, 1, 0));  ex.push_back(expv(3, 0, 0, 0, 0));
    st.push_back(row(0, 0, 0, 0, 1, 0));  ex.push_back(expv(3, 0, 0, 0, 0));
    for (int i = 0; i < st.size(); i++) begin
      @(negedge clk); apply(st[i]); sb.push_back(ex[i]);
      @(posedge clk); #1;
      want = sb.pop_front(); checks++;
      if (obs !== want) begin
        errors++; $display("FAIL priority[%0d] got %s want %s", i, fmt(obs), fmt(want));
      end
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_saturate();
    test_oneshot();
    test_reload();
    test_mode_switch();
    test_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
